ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single data/instruction RAM port between two requesters: the CPU memory interface (port 0) and a DMA/loader engine (port 1).
- Round-robin arbitration, one access in flight at a time.
- Registered grant, issue and response handshake; parameterised RAM read latency.
- Sits between the CPU top level and the RAM model; the CPU's ram_* signals connect to port 0.

Parameters:
- RD_LATENCY, 1, cycles from ram_en asserted to ram_rdata valid; legal range 1-4.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  access request; held with fields stable until pX_gnt
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  byte address
- p0_mask / p1_mask  in  2  access-size mask, passed through unchanged
- p0_signed_ext / p1_signed_ext  in  1  load sign-extend, passed through
- p0_wdata / p1_wdata  in  32  write data
- p0_gnt / p1_gnt  out  1  one-cycle pulse: request accepted and fields latched
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse: access complete (reads and writes)
- p0_rdata / p1_rdata  out  32  read data, valid while pX_rvalid=1
- ram_en  out  1  one-cycle access strobe
- ram_we, ram_addr[ADDR_W], ram_mask[2], ram_signed_ext, ram_wdata[32]  out  latched fields of the winner
- ram_rdata  in  32  RAM read data

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, last_winner=P1 (so P0 wins the first tie).
  - All gnt, rvalid, ram_en and ram_we are 0; rdata and ram fields are 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Samples the reqs.
  - Only one req high: that port wins.
  - Both high: the port other than last_winner wins.
  - Neither high: stay in IDLE.
  - On a win: latch the winner's fields, set the winner id and last_winner, go to ISSUE.
- ISSUE (1 cycle):
  - pX_gnt=1 for the winner.
  - ram_en=1; ram_* outputs show the latched fields.
  - Load wait counter with RD_LATENCY-1, then go to WAIT.
  - ram_* field outputs hold their latched values until the next ISSUE.
- WAIT:
  - Decrement the counter.
  - In the cycle where the counter is 0, register ram_rdata into the winner's rdata and go to RESP.
  - RD_LATENCY=1 means WAIT lasts exactly one cycle.
- RESP (1 cycle): pX_rvalid=1 for the winner; go to IDLE.
- Timing:
  - req sampled at cycle T -> gnt at T+1 -> rvalid at T+RD_LATENCY+2.
  - Back-to-back access period is RD_LATENCY+3 cycles.
- Requester rules:
  - Must drop req in the cycle after gnt, or keep it high to issue a new request (sampled in the next IDLE).
  - The loser's req stays pending and is not dropped.
- rdata of the non-winning port holds its previous value.
- Reset during ISSUE, WAIT or RESP: the in-flight access is abandoned and no rvalid is produced; RAM write side effects already issued stand.
- A req asserted during a non-IDLE state is only considered in IDLE; there is no queueing beyond the req level.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - Adds input ports p0_lock / p1_lock (1 bit each).
  - In IDLE, if the lock of last_winner is high, only last_winner is eligible and the other port is blocked even if requesting.
  - Used for atomic read-modify-write by DMA.
- Undefined: the lock ports do not exist and arbitration is pure round-robin.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - requester id constants (PORT_CPU=0, PORT_DMA=1);
  - mask width constant;
  - RD_LATENCY legal-range limits.
- One sub-module, rr_arbiter2:
  - combinational winner select from the two reqs plus last_winner (plus lock when RAM_ARB_LOCK_EN is defined);
  - the pointer register stays in the parent.

Test Plan:
- Single read: RD_LATENCY=1, p0 read of 0x0000_0010, RAM returns 0xDEADBEEF -> p0_gnt at T+1, ram_en with addr 0x10 at T+1, p0_rvalid with rdata 0xDEADBEEF at T+3; p1 outputs unchanged.
- Tie, round-robin: p0_req and p1_req held high, 4 accesses -> grant order P0,P1,P0,P1; gnt pulses spaced RD_LATENCY+3 cycles apart.
- Write pass-through: p1 write to addr 0x100, wdata 0x12345678, mask 2'b01 -> ram_we=1 with exactly those fields for one cycle; p1_rvalid at T+RD_LATENCY+2.
- Latency sweep: RD_LATENCY=4 read -> rvalid at T+6; ram_rdata is sampled only in the final WAIT cycle, and garbage on earlier cycles is never returned.
- Reset mid-access: assert reset during WAIT -> all outputs 0 immediately, no rvalid; after release, p0_req is granted at the next cycle's ISSUE.
- RAM_ARB_LOCK_EN defined: p1 wins with p1_lock=1 while p0_req stays high -> p1 wins 3 consecutive accesses; p1_lock dropped -> p0 granted next.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int MASK_W = 2;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  // Wide enough to hold RD_LAT_MAX-1.
  localparam int CNT_W = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational round-robin winner select for two requesters.
// With RAM_ARB_LOCK_EN defined, a locked last winner blocks the other port.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
`ifdef RAM_ARB_LOCK_EN
  input  logic lock0,
  input  logic lock1,
`endif
  output logic valid,
  output logic winner
);

  logic elig0;
  logic elig1;

  always_comb begin
    elig0 = req0;
    elig1 = req1;
`ifdef RAM_ARB_LOCK_EN
    if (last_winner == PORT_DMA && lock1) elig0 = 1'b0;
    if (last_winner == PORT_CPU && lock0) elig1 = 1'b0;
`endif
    valid = elig0 | elig1;
    if (elig0 && elig1) begin
      winner = ~last_winner;
    end else if (elig1) begin
      winner = PORT_DMA;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the CPU (port 0) and a DMA/loader (port 1).
// Optional RAM_ARB_LOCK_EN adds p0_lock/p1_lock for atomic sequences.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [MASK_W-1:0] p0_mask,
  input  logic              p0_signed_ext,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [MASK_W-1:0] p1_mask,
  input  logic              p1_signed_ext,
  input  logic [31:0]       p1_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic              p0_lock,
  input  logic              p1_lock,
`endif
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [31:0]       p0_rdata,
  output logic [31:0]       p1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [MASK_W-1:0] ram_mask,
  output logic              ram_signed_ext,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
    $error("ram_port_arbiter: RD_LATENCY must be within 1..4");
  end

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             winner_q;
  logic             last_winner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic             arb_valid;
  logic             arb_winner;

  rr_arbiter2 u_rr_arbiter2 (
    .req0        (p0_req),
    .req1        (p1_req),
    .last_winner (last_winner_q),
`ifdef RAM_ARB_LOCK_EN
    .lock0       (p0_lock),
    .lock1       (p1_lock),
`endif
    .valid       (arb_valid),
    .winner      (arb_winner)
  );

  // Fields are latched only on a win, so ram_* hold until the next access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      winner_q       <= PORT_CPU;
      last_winner_q  <= PORT_DMA;
      we_q           <= 1'b0;
      cnt_q          <= '0;
      ram_addr       <= '0;
      ram_mask       <= '0;
      ram_signed_ext <= 1'b0;
      ram_wdata      <= '0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            winner_q      <= arb_winner;
            last_winner_q <= arb_winner;
            if (arb_winner == PORT_DMA) begin
              we_q           <= p1_we;
              ram_addr       <= p1_addr;
              ram_mask       <= p1_mask;
              ram_signed_ext <= p1_signed_ext;
              ram_wdata      <= p1_wdata;
            end else begin
              we_q           <= p0_we;
              ram_addr       <= p0_addr;
              ram_mask       <= p0_mask;
              ram_signed_ext <= p0_signed_ext;
              ram_wdata      <= p0_wdata;
            end
          end
        end
        ISSUE: cnt_q <= CNT_LOAD;
        WAIT: begin
          // RAM data is only valid on the last WAIT cycle.
          if (cnt_q == '0) begin
            if (winner_q == PORT_DMA) p1_rdata <= ram_rdata;
            else                      p0_rdata <= ram_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        ram_en  = 1'b1;
        ram_we  = we_q;
        p0_gnt  = (winner_q == PORT_CPU);
        p1_gnt  = (winner_q == PORT_DMA);
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        state_d   = IDLE;
        p0_rvalid = (winner_q == PORT_CPU);
        p1_rvalid = (winner_q == PORT_DMA);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: two arbiter instances (RD_LATENCY 1 and 4) against a
// transaction-timeline reference model; exercises RAM_ARB_LOCK_EN when defined.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int NI = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   [NI][2];
  logic        we    [NI][2];
  logic [31:0] addr  [NI][2];
  logic [1:0]  mask  [NI][2];
  logic        sext  [NI][2];
  logic [31:0] wdata [NI][2];
`ifdef RAM_ARB_LOCK_EN
  logic        lock  [NI][2];
`endif
  logic [31:0] ram_rdata [NI];

  wire         gnt    [NI][2];
  wire         rvalid [NI][2];
  wire  [31:0] rdata  [NI][2];
  wire         ram_en    [NI];
  wire         ram_we    [NI];
  wire  [31:0] ram_addr  [NI];
  wire  [1:0]  ram_mask  [NI];
  wire         ram_sext  [NI];
  wire  [31:0] ram_wdata [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_port_arbiter #(.RD_LATENCY(g == 0 ? 1 : 4), .ADDR_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .p0_req         (req[g][0]),
      .p0_we          (we[g][0]),
      .p0_addr        (addr[g][0]),
      .p0_mask        (mask[g][0]),
      .p0_signed_ext  (sext[g][0]),
      .p0_wdata       (wdata[g][0]),
      .p1_req         (req[g][1]),
      .p1_we          (we[g][1]),
      .p1_addr        (addr[g][1]),
      .p1_mask        (mask[g][1]),
      .p1_signed_ext  (sext[g][1]),
      .p1_wdata       (wdata[g][1]),
`ifdef RAM_ARB_LOCK_EN
      .p0_lock        (lock[g][0]),
      .p1_lock        (lock[g][1]),
`endif
      .p0_gnt         (gnt[g][0]),
      .p1_gnt         (gnt[g][1]),
      .p0_rvalid      (rvalid[g][0]),
      .p1_rvalid      (rvalid[g][1]),
      .p0_rdata       (rdata[g][0]),
      .p1_rdata       (rdata[g][1]),
      .ram_en         (ram_en[g]),
      .ram_we         (ram_we[g]),
      .ram_addr       (ram_addr[g]),
      .ram_mask       (ram_mask[g]),
      .ram_signed_ext (ram_sext[g]),
      .ram_wdata      (ram_wdata[g]),
      .ram_rdata      (ram_rdata[g])
    );
  end

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  bit in_reset   = 1'b1;
  bit auto_mode  = 1'b0;
  bit rec_q      = 1'b0;
  bit keep [NI][2];

  // Reference model: each access is a timeline of absolute cycle numbers.
  int          free_at  [NI];
  int          gnt_cyc  [NI];
  int          resp_cyc [NI];
  bit          win      [NI];
  bit          lastw    [NI];
  logic        p_we     [NI];
  logic [31:0] p_addr   [NI];
  logic [1:0]  p_mask   [NI];
  logic        p_sext   [NI];
  logic [31:0] p_wdata  [NI];
  logic [31:0] p_resp   [NI];
  logic        e_we     [NI];
  logic [31:0] e_addr   [NI];
  logic [1:0]  e_mask   [NI];
  logic        e_sext   [NI];
  logic [31:0] e_wdata  [NI];
  logic [31:0] exp_rdata [NI][2];

  logic        hist_en   [NI][8];
  logic [31:0] hist_addr [NI][8];
  int          hist_cyc  [NI][8];

  int          obs_gnt [NI][2];
  int          obs_rv  [NI][2];
  int          gq_port [NI][$];
  int          gq_cyc  [NI][$];
  logic        le_we    [NI];
  logic [31:0] le_addr  [NI];
  logic [1:0]  le_mask  [NI];
  logic [31:0] le_wdata [NI];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ram_value(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input int i, input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL i%0d %s: observed %h expected %h (cycle %0d)", i, name, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      gnt_cyc[i] = -1; resp_cyc[i] = -1; free_at[i] = 0;
      win[i] = 1'b0; lastw[i] = 1'b1;
      e_we[i] = 1'b0; e_addr[i] = '0; e_mask[i] = '0; e_sext[i] = 1'b0; e_wdata[i] = '0;
      exp_rdata[i][0] = '0; exp_rdata[i][1] = '0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NI; i++) begin
      obs_gnt[i][0] = -1; obs_gnt[i][1] = -1; obs_rv[i][0] = -1; obs_rv[i][1] = -1;
      le_we[i] = 1'b0; le_addr[i] = '0; le_mask[i] = '0; le_wdata[i] = '0;
      gq_port[i].delete(); gq_cyc[i].delete();
    end
  endtask

  task automatic set_fields(input int i, input int p, input logic w, input logic [31:0] a,
                            input logic [1:0] m, input logic s, input logic [31:0] d);
    we[i][p] = w; addr[i][p] = a; mask[i][p] = m; sext[i][p] = s; wdata[i][p] = d;
  endtask

  task automatic rand_fields(input int i, input int p);
    set_fields(i, p, 1'($urandom % 2), $urandom, 2'($urandom % 4), 1'($urandom % 2), $urandom);
  endtask

  // Round-robin rule applied to the request levels present in an idle cycle.
  task automatic model_decide(input int i);
    bit r0, r1, w;
    if (in_reset || cyc < free_at[i]) return;
    r0 = req[i][0];
    r1 = req[i][1];
`ifdef RAM_ARB_LOCK_EN
    if (lock[i][lastw[i]]) begin
      if (lastw[i]) r0 = 1'b0;
      else          r1 = 1'b0;
    end
`endif
    if (!r0 && !r1) return;
    w = (r0 && r1) ? !lastw[i] : r1;
    win[i] = w; lastw[i] = w;
    gnt_cyc[i]  = cyc + 1;
    resp_cyc[i] = cyc + lat_of(i) + 2;
    free_at[i]  = cyc + lat_of(i) + 3;
    p_we[i] = we[i][w]; p_addr[i] = addr[i][w]; p_mask[i] = mask[i][w];
    p_sext[i] = sext[i][w]; p_wdata[i] = wdata[i][w];
    p_resp[i] = ram_value(addr[i][w]);
  endtask

  // RAM model: valid data exactly RD_LATENCY cycles after ram_en, garbage otherwise.
  task automatic drive_ram(input int i);
    int k;
    k = cyc - lat_of(i);
    if (k >= 0 && hist_cyc[i][k % 8] == k && hist_en[i][k % 8] === 1'b1)
      ram_rdata[i] = ram_value(hist_addr[i][k % 8]);
    else
      ram_rdata[i] = $urandom;
  endtask

  task automatic check_cycle(input int i);
    bit een, er;
    int slot;
    een = (cyc == gnt_cyc[i]);
    er  = (cyc == resp_cyc[i]);
    if (een) begin
      e_we[i] = p_we[i]; e_addr[i] = p_addr[i]; e_mask[i] = p_mask[i];
      e_sext[i] = p_sext[i]; e_wdata[i] = p_wdata[i];
    end
    if (er) exp_rdata[i][win[i]] = p_resp[i];
    chk(i, "p0_gnt",    32'(gnt[i][0]),    32'(een && !win[i]));
    chk(i, "p1_gnt",    32'(gnt[i][1]),    32'(een && win[i]));
    chk(i, "p0_rvalid", 32'(rvalid[i][0]), 32'(er && !win[i]));
    chk(i, "p1_rvalid", 32'(rvalid[i][1]), 32'(er && win[i]));
    chk(i, "p0_rdata",  rdata[i][0],       exp_rdata[i][0]);
    chk(i, "p1_rdata",  rdata[i][1],       exp_rdata[i][1]);
    chk(i, "ram_en",    32'(ram_en[i]),    32'(een));
    chk(i, "ram_addr",  ram_addr[i],       e_addr[i]);
    chk(i, "ram_mask",  32'(ram_mask[i]),  32'(e_mask[i]));
    chk(i, "ram_sext",  32'(ram_sext[i]),  32'(e_sext[i]));
    chk(i, "ram_wdata", ram_wdata[i],      e_wdata[i]);
    if (een) chk(i, "ram_we", 32'(ram_we[i]), 32'(e_we[i]));
    slot = cyc % 8;
    hist_en[i][slot] = ram_en[i]; hist_addr[i][slot] = ram_addr[i]; hist_cyc[i][slot] = cyc;
    for (int p = 0; p < 2; p++) begin
      if (gnt[i][p] === 1'b1) begin
        obs_gnt[i][p] = cyc;
        if (rec_q && gq_port[i].size() < 4) begin
          gq_port[i].push_back(p);
          gq_cyc[i].push_back(cyc);
        end
      end
      if (rvalid[i][p] === 1'b1) obs_rv[i][p] = cyc;
    end
    if (ram_en[i] === 1'b1) begin
      le_we[i] = ram_we[i]; le_addr[i] = ram_addr[i]; le_mask[i] = ram_mask[i]; le_wdata[i] = ram_wdata[i];
    end
  endtask

  // Requesters drop (or renew) right after their grant; random mode also raises new requests.
  task automatic auto_drive(input int i);
    for (int p = 0; p < 2; p++) begin
      if (cyc == gnt_cyc[i] && int'(win[i]) == p) begin
        if (auto_mode) begin
          if ($urandom % 2 == 1) rand_fields(i, p);
          else                   req[i][p] = 1'b0;
        end else if (!keep[i][p]) begin
          req[i][p] = 1'b0;
        end
      end else if (auto_mode && req[i][p] !== 1'b1 && ($urandom % 3 == 0)) begin
        rand_fields(i, p);
        req[i][p] = 1'b1;
      end
`ifdef RAM_ARB_LOCK_EN
      if (auto_mode) lock[i][p] = ($urandom % 4 == 0);
`endif
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      model_decide(i);
      drive_ram(i);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_cycle(i);
      auto_drive(i);
    end
  endtask

  task automatic check_zero();
    for (int i = 0; i < NI; i++) begin
      chk(i, "rst p0_gnt",    32'(gnt[i][0]),    0);
      chk(i, "rst p1_gnt",    32'(gnt[i][1]),    0);
      chk(i, "rst p0_rvalid", 32'(rvalid[i][0]), 0);
      chk(i, "rst p1_rvalid", 32'(rvalid[i][1]), 0);
      chk(i, "rst ram_en",    32'(ram_en[i]),    0);
      chk(i, "rst ram_we",    32'(ram_we[i]),    0);
      chk(i, "rst ram_addr",  ram_addr[i],       0);
      chk(i, "rst ram_wdata", ram_wdata[i],      0);
      chk(i, "rst p0_rdata",  rdata[i][0],       0);
      chk(i, "rst p1_rdata",  rdata[i][1],       0);
    end
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    check_zero();
    in_reset = 1'b1;
    model_reset();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    in_reset = 1'b0;
    for (int i = 0; i < NI; i++) free_at[i] = cyc;
  endtask

  task automatic drop_all();
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0;
        keep[i][p] = 1'b0;
`ifdef RAM_ARB_LOCK_EN
        lock[i][p] = 1'b0;
`endif
      end
  endtask

  initial begin
    int t0;
    int rel;
    bit done;
    for (int i = 0; i < NI; i++) begin
      ram_rdata[i] = '0;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; keep[i][p] = 1'b0;
        set_fields(i, p, 1'b0, '0, '0, 1'b0, '0);
`ifdef RAM_ARB_LOCK_EN
        lock[i][p] = 1'b0;
`endif
      end
      for (int s = 0; s < 8; s++) begin
        hist_en[i][s] = 1'b0; hist_addr[i][s] = '0; hist_cyc[i][s] = -1;
      end
    end
    model_reset();
    clear_obs();
    #1;
    check_zero();
    repeat (3) tick();
    release_reset();

    // Single read of 0x10 on port 0.
    t0 = cyc;
    clear_obs();
    for (int i = 0; i < NI; i++) begin
      set_fields(i, 0, 1'b0, 32'h0000_0010, 2'b10, 1'b0, '0);
      req[i][0] = 1'b1;
    end
    repeat (10) tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "read gnt cycle",   obs_gnt[i][0] - t0, 1);
      chk(i, "read rvalid cycle", obs_rv[i][0] - t0, lat_of(i) + 2);
      chk(i, "read rdata",        rdata[i][0], 32'hDEAD_BEEF);
      chk(i, "read p1 no gnt",    obs_gnt[i][1], -1);
      chk(i, "read p1 rdata",     rdata[i][1], 0);
    end

    // Tie with both requests held: strict alternation starting with port 0.
    assert_reset();
    repeat (2) tick();
    release_reset();
    clear_obs();
    rec_q = 1'b1;
    for (int i = 0; i < NI; i++) begin
      set_fields(i, 0, 1'b0, 32'h0000_0020, 2'b11, 1'b1, '0);
      set_fields(i, 1, 1'b0, 32'h0000_0024, 2'b00, 1'b0, '0);
      req[i][0] = 1'b1; req[i][1] = 1'b1;
      keep[i][0] = 1'b1; keep[i][1] = 1'b1;
    end
    repeat (34) tick();
    drop_all();
    rec_q = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "tie grant count", gq_port[i].size(), 4);
      for (int n = 0; n < 4; n++) begin
        chk(i, $sformatf("tie grant %0d port", n), gq_port[i][n], n % 2);
        if (n > 0) chk(i, $sformatf("tie grant %0d spacing", n), gq_cyc[i][n] - gq_cyc[i][n-1], lat_of(i) + 3);
      end
    end

    // Write pass-through on port 1.
    t0 = cyc;
    clear_obs();
    for (int i = 0; i < NI; i++) begin
      set_fields(i, 1, 1'b1, 32'h0000_0100, 2'b01, 1'b0, 32'h1234_5678);
      req[i][1] = 1'b1;
    end
    repeat (10) tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "write gnt cycle",    obs_gnt[i][1] - t0, 1);
      chk(i, "write rvalid cycle", obs_rv[i][1] - t0, lat_of(i) + 2);
      chk(i, "write ram_we",       32'(le_we[i]), 1);
      chk(i, "write ram_addr",     le_addr[i], 32'h0000_0100);
      chk(i, "write ram_mask",     32'(le_mask[i]), 1);
      chk(i, "write ram_wdata",    le_wdata[i], 32'h1234_5678);
    end

    // Reset while the access sits in WAIT; a fresh request follows.
    clear_obs();
    for (int i = 0; i < NI; i++) begin
      set_fields(i, 0, 1'b0, 32'h0000_0040, 2'b10, 1'b0, '0);
      req[i][0] = 1'b1;
    end
    repeat (2) tick();
    assert_reset();
    for (int i = 0; i < NI; i++) begin
      set_fields(i, 0, 1'b0, 32'h0000_0080, 2'b10, 1'b0, '0);
      req[i][0] = 1'b1;
    end
    repeat (2) tick();
    clear_obs();
    rel = cyc;
    release_reset();
    repeat (10) tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "post-reset gnt cycle",    obs_gnt[i][0] - rel, 1);
      chk(i, "post-reset rvalid cycle", obs_rv[i][0] - rel, lat_of(i) + 2);
      chk(i, "post-reset rdata",        rdata[i][0], ram_value(32'h0000_0080));
    end

`ifdef RAM_ARB_LOCK_EN
    // Port 1 holds its lock for three accesses, then releases it to port 0.
    assert_reset();
    repeat (2) tick();
    release_reset();
    clear_obs();
    rec_q = 1'b1;
    for (int i = 0; i < NI; i++) begin
      set_fields(i, 0, 1'b0, 32'h0000_0200, 2'b10, 1'b0, '0);
      set_fields(i, 1, 1'b1, 32'h0000_0300, 2'b10, 1'b0, 32'hCAFE_0001);
      req[i][0] = 1'b1; req[i][1] = 1'b1;
      keep[i][0] = 1'b1; keep[i][1] = 1'b1;
      lock[i][1] = 1'b1;
    end
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (gq_port[i].size() >= 3) lock[i][1] = 1'b0;
        if (gq_port[i].size() < 4) done = 1'b0;
      end
    end
    drop_all();
    rec_q = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "lock grant count", gq_port[i].size(), 4);
      for (int n = 0; n < 4; n++)
        chk(i, $sformatf("lock grant %0d port", n), gq_port[i][n], (n < 3) ? 1 : 0);
    end
`endif

    // Random traffic with a reset pulse in the middle.
    done = 1'b0;
    auto_mode = 1'b1;
    repeat (700) tick();
    assert_reset();
    repeat (2) tick();
    release_reset();
    repeat (800) tick();
    auto_mode = 1'b0;
    drop_all();
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
